i2c_byte_master: RTL
====================

Name: i2c_byte_master

Overview:
Byte-level I2C master that drives the scl/sda lines the slave BFM interface monitors and responds to.
- Accepts START, STOP, WRITE-byte and READ-byte commands over a valid/ready handshake.
- Generates open-drain SCL/SDA waveforms and returns the read data and ACK status per command.
- Serves as the bus-driving stage of the multi-bus controller and as the stimulus source for the slave BFM.

Parameters:
- CLK_DIV, 250: system clocks per quarter bit period; legal range 2..65535; bit period = 4*CLK_DIV clocks.
- I2C_DATA_WIDTH, 8: bits per data byte.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00=START, 01=STOP, 10=WRITE, 11=READ.
- cmd_wdata  input  I2C_DATA_WIDTH  byte to write (WRITE only).
- cmd_nack  input  1  READ only: 1 = master sends NACK after the byte, 0 = ACK.
- rsp_valid  output  1  one-cycle pulse: command complete.
- rsp_rdata  output  I2C_DATA_WIDTH  byte read (READ only; holds its value otherwise).
- rsp_err  output  1  WRITE: slave NACKed; WRITE/READ issued without a prior START: protocol error.
- busy  output  1  bus is owned (START issued, STOP not yet issued).
- scl_i  input  1  sampled SCL line.
- sda_i  input  1  sampled SDA line.
- scl_o  output  1  0 = pull SCL low, 1 = release.
- sda_o  output  1  0 = pull SDA low, 1 = release.

Behaviour:
- Reset values: scl_o=1, sda_o=1, cmd_ready=0 while rst is high, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state IDLE, quarter counter 0.
- cmd_ready=1 only in IDLE with rst low. A command is accepted on the clk edge where cmd_valid && cmd_ready. cmd_ready falls the next cycle.
- Quarter tick: a counter counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. Each bit uses quarters q0..q3.
- States: IDLE, START, STOP, XFER_BIT, ACK_BIT, RESP.
- START, 4 quarters:
  - q0: sda_o=1.
  - q1: scl_o=1.
  - q2: sda_o=0 (SDA falls while SCL is high).
  - q3: scl_o=0.
  - Sets busy=1. Legal while busy=1 (repeated START).
- STOP, 4 quarters:
  - q0: sda_o=0.
  - q1: scl_o=1.
  - q2: sda_o=1 (SDA rises while SCL is high).
  - q3: idle.
  - Clears busy.
  - STOP while busy=0: no bus activity; rsp_valid 1 cycle after acceptance, rsp_err=0.
- WRITE:
  - 8 XFER_BIT bits, MSB first:
    - q0: sda_o=bit.
    - q1: scl_o=1.
    - q2: hold.
    - q3: scl_o=0.
  - ACK_BIT:
    - q0: sda_o=1.
    - q2: sample sda_i; rsp_err = sampled value (1 = NACK).
- READ:
  - 8 XFER_BIT bits with sda_o=1; sample sda_i into a shift register at q2, MSB first.
  - ACK_BIT: q0 drives sda_o = latched cmd_nack.
- WRITE/READ while busy=0: no bus activity; rsp_valid 1 cycle after acceptance with rsp_err=1.
- Every bus command ends with SCL low (except STOP), then RESP: rsp_valid=1 for exactly one cycle, rsp_rdata/rsp_err updated in that same cycle, return to IDLE. cmd_ready is high the following cycle.
- Latency, acceptance to rsp_valid:
  - START/STOP: 4*CLK_DIV+1 clocks.
  - WRITE/READ: 36*CLK_DIV+1 clocks.
- Command inputs are latched at acceptance; later changes to them are ignored.
- Reset mid-operation: both lines are released at the reset edge, no STOP is generated, busy=0, and the in-flight command produces no response.
- cmd_valid while not ready is ignored; the command is not queued.

Optional Feature:
I2C_MASTER_CLK_STRETCH_EN
- Defined: in every quarter where scl_o=1, the quarter counter holds at 0 while scl_i==0. A slave stretching SCL delays the bit, and no sample is taken before SCL is actually high.
- Undefined: scl_i is unused and timing is purely counter-driven.

Test Plan:
- CLK_DIV=4; reset; START -> on SCL high, SDA falls; busy=1; rsp_valid 17 clocks after acceptance.
- START, WRITE 0x44, slave ACK -> BFM captures saddr=0x22, op=WRITE; rsp_err=0; rsp_valid 145 clocks after acceptance.
- START, WRITE 0x45, READ with cmd_nack=1, slave drives 0xA5 -> rsp_rdata=0xA5; sda_o=1 during the 9th SCL pulse; then STOP -> busy=0 and the BFM stop flag is set.
- START, WRITE 0x10, sda_i left high at the ACK bit -> rsp_err=1; STOP still completes normally.
- WRITE with busy=0 -> rsp_valid on the cycle after acceptance, rsp_err=1, scl_o/sda_o stay 1.
- rst asserted at bit 4 of a WRITE -> next cycle scl_o=1, sda_o=1, busy=0, no rsp_valid; the cycle after rst deasserts, cmd_ready=1.

Source files
------------

// File: rtl/i2c_byte_master_if.sv
// i2c_byte_master_if -- command/response handshake and open-drain line bundle
// for the byte-level I2C master.
//
// Modports:
//   master : the I2C master block itself. It takes commands and the sampled
//            lines, and drives cmd_ready, the response, busy and the line enables.
//   slave  : the environment around the master. It issues commands, consumes
//            responses and returns the resolved SCL/SDA line levels.
//
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00=START 01=STOP 10=WRITE 11=READ
//   cmd_wdata             byte to write (WRITE)
//   cmd_nack              READ: 1 = NACK after the byte, 0 = ACK
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             byte read (READ, held otherwise)
//   rsp_err               slave NACK on WRITE, or WRITE/READ without bus ownership
//   busy                  bus owned (START issued, STOP not yet issued)
//   scl_i/sda_i           resolved line levels
//   scl_o/sda_o           0 = pull low, 1 = release
interface i2c_byte_master_if #(
   parameter int I2C_DATA_WIDTH = 8
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [1:0]                cmd_op;
   logic [I2C_DATA_WIDTH-1:0] cmd_wdata;
   logic                      cmd_nack;
   logic                      rsp_valid;
   logic [I2C_DATA_WIDTH-1:0] rsp_rdata;
   logic                      rsp_err;
   logic                      busy;
   logic                      scl_i;
   logic                      sda_i;
   logic                      scl_o;
   logic                      sda_o;

   modport master (
      input  cmd_valid, cmd_op, cmd_wdata, cmd_nack, scl_i, sda_i,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, scl_o, sda_o
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_wdata, cmd_nack, scl_i, sda_i,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, scl_o, sda_o
   );
endinterface

// File: rtl/i2c_byte_master.sv
// i2c_byte_master -- byte-level I2C master.
//
// Accepts START / STOP / WRITE-byte / READ-byte commands over a valid/ready
// handshake and generates open-drain SCL/SDA waveforms. Each bit uses four
// quarters of CLK_DIV system clocks. Every command ends with a one-cycle
// rsp_valid pulse carrying rsp_rdata / rsp_err.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  i2c_byte_master_if.master (command, response, busy, SCL/SDA lines)
//
// Parameters:
//   CLK_DIV         system clocks per quarter bit period (2..65535)
//   I2C_DATA_WIDTH  bits per data byte
//
// Optional build macro:
//   I2C_MASTER_CLK_STRETCH_EN  when defined, the quarter counter holds at 0
//   while this block releases SCL but the line still reads low, so a slave can
//   stretch the clock. When undefined, scl_i is ignored.
module i2c_byte_master #(
   parameter int CLK_DIV        = 250,
   parameter int I2C_DATA_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   i2c_byte_master_if.master bus
);
   localparam int BIT_W = (I2C_DATA_WIDTH > 1) ? $clog2(I2C_DATA_WIDTH) : 1;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      STOP     = 3'd2,
      XFER_BIT = 3'd3,
      ACK_BIT  = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt;
   logic [15:0]               qcnt_r;
   logic [1:0]                quarter_r;
   logic [BIT_W-1:0]          bit_cnt_r;
   logic [1:0]                op_r;
   logic                      nack_r;
   logic                      err_r;
   logic [I2C_DATA_WIDTH-1:0] shift_r;
   logic                      scl_r;
   logic                      sda_r;
   logic                      ready_r;
   logic                      rsp_valid_r;
   logic                      rsp_err_r;
   logic                      busy_r;
   logic [I2C_DATA_WIDTH-1:0] rsp_rdata_r;
   logic                      scl_nxt_s;
   logic                      sda_nxt_s;
   logic                      accept_s;
   logic                      on_bus_s;
   logic                      hold_s;
   logic                      tick_s;

   assign accept_s = bus.cmd_valid && ready_r;
   assign on_bus_s = (state_r == START) || (state_r == STOP) ||
                     (state_r == XFER_BIT) || (state_r == ACK_BIT);

`ifdef I2C_MASTER_CLK_STRETCH_EN
   // SCL released by us but still low: a slave is stretching the clock.
   assign hold_s = on_bus_s && scl_r && !bus.scl_i;
`else
   logic scl_unused_s;
   assign scl_unused_s = bus.scl_i;
   assign hold_s       = 1'b0;
`endif

   assign tick_s = on_bus_s && !hold_s && (qcnt_r == 16'(CLK_DIV - 1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next state and next line levels; a line keeps its level unless the
   // current quarter says otherwise.
   always_comb begin
      state_nxt = state_r;
      scl_nxt_s = scl_r;
      sda_nxt_s = sda_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               case (bus.cmd_op)
                  OP_START: state_nxt = START;
                  OP_STOP:  state_nxt = busy_r ? STOP : RESP;
                  default:  state_nxt = busy_r ? XFER_BIT : RESP;
               endcase
            end else begin
               state_nxt = IDLE;
            end
         end
         START: begin
            case (quarter_r)
               2'd0:    sda_nxt_s = 1'b1;
               2'd1:    scl_nxt_s = 1'b1;
               2'd2:    sda_nxt_s = 1'b0;
               default: scl_nxt_s = 1'b0;
            endcase
            if (tick_s && (quarter_r == 2'd3)) begin
               state_nxt = RESP;
            end else begin
               state_nxt = START;
            end
         end
         STOP: begin
            case (quarter_r)
               2'd0:    sda_nxt_s = 1'b0;
               2'd1:    scl_nxt_s = 1'b1;
               2'd2:    sda_nxt_s = 1'b1;
               default: scl_nxt_s = 1'b1;
            endcase
            if (tick_s && (quarter_r == 2'd3)) begin
               state_nxt = RESP;
            end else begin
               state_nxt = STOP;
            end
         end
         XFER_BIT: begin
            case (quarter_r)
               2'd0:    sda_nxt_s = (op_r == OP_WRITE) ? shift_r[I2C_DATA_WIDTH-1] : 1'b1;
               2'd1:    scl_nxt_s = 1'b1;
               2'd2:    sda_nxt_s = sda_r;
               default: scl_nxt_s = 1'b0;
            endcase
            if (tick_s && (quarter_r == 2'd3) && (bit_cnt_r == '0)) begin
               state_nxt = ACK_BIT;
            end else begin
               state_nxt = XFER_BIT;
            end
         end
         ACK_BIT: begin
            case (quarter_r)
               2'd0:    sda_nxt_s = (op_r == OP_WRITE) ? 1'b1 : nack_r;
               2'd1:    scl_nxt_s = 1'b1;
               2'd2:    sda_nxt_s = sda_r;
               default: scl_nxt_s = 1'b0;
            endcase
            if (tick_s && (quarter_r == 2'd3)) begin
               state_nxt = RESP;
            end else begin
               state_nxt = ACK_BIT;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: lines, quarter timing, command latch, shifter and response.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_r       <= 1'b1;
         sda_r       <= 1'b1;
         ready_r     <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= '0;
         busy_r      <= 1'b0;
         qcnt_r      <= 16'd0;
         quarter_r   <= 2'd0;
         bit_cnt_r   <= '0;
         op_r        <= 2'b00;
         nack_r      <= 1'b0;
         err_r       <= 1'b0;
         shift_r     <= '0;
      end else begin
         scl_r       <= scl_nxt_s;
         sda_r       <= sda_nxt_s;
         // Ready only in a settled IDLE cycle, so it rises the cycle after rsp_valid.
         ready_r     <= (state_r == IDLE) && !accept_s;
         rsp_valid_r <= (state_r == RESP);

         if (!on_bus_s || hold_s) begin
            qcnt_r <= 16'd0;
            if (!on_bus_s) begin
               quarter_r <= 2'd0;
            end
         end else if (tick_s) begin
            qcnt_r    <= 16'd0;
            quarter_r <= quarter_r + 2'd1;
         end else begin
            qcnt_r <= qcnt_r + 16'd1;
         end

         if (accept_s) begin
            op_r      <= bus.cmd_op;
            nack_r    <= bus.cmd_nack;
            shift_r   <= bus.cmd_wdata;
            bit_cnt_r <= BIT_W'(I2C_DATA_WIDTH - 1);
            // WRITE/READ without bus ownership is answered with an error.
            err_r     <= bus.cmd_op[1] && !busy_r;
         end else if ((state_r == XFER_BIT) && tick_s && (quarter_r == 2'd2)) begin
            shift_r <= {shift_r[I2C_DATA_WIDTH-2:0], bus.sda_i};
         end else if ((state_r == ACK_BIT) && tick_s && (quarter_r == 2'd2) &&
                      (op_r == OP_WRITE)) begin
            err_r <= bus.sda_i;
         end

         if ((state_r == XFER_BIT) && tick_s && (quarter_r == 2'd3)) begin
            bit_cnt_r <= bit_cnt_r - BIT_W'(1);
         end

         if (state_r == RESP) begin
            rsp_err_r <= err_r;
            if ((op_r == OP_READ) && !err_r) begin
               rsp_rdata_r <= shift_r;
            end
            if (op_r == OP_START) begin
               busy_r <= 1'b1;
            end else if (op_r == OP_STOP) begin
               busy_r <= 1'b0;
            end
         end
      end
   end

   assign bus.cmd_ready = ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.busy      = busy_r;
   assign bus.scl_o     = scl_r;
   assign bus.sda_o     = sda_r;
endmodule
